// File: rtl/deser_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : deser_demux8
//  Purpose  : Serial-to-parallel deserializer; steers the k-th bit of a frame
//             to word position k and emits the word over valid/ready.
//  Revision : 1.0
// ============================================================================
module deser_demux8 #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W:0]   out_len,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SEL_W-1:0] c_last_pos = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] c_cnt_one  = {{(SEL_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_acc;
    logic [SEL_W-1:0] r_cnt;
    logic             r_pend;
    logic [SEL_W:0]   r_pend_len;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W:0]   r_out_len;
    logic             r_out_valid;

    logic [SEL_W-1:0] w_pos;
    logic [WIDTH-1:0] w_word;
    logic [SEL_W:0]   w_len;
    logic             w_accept;
    logic             w_done;
    logic             w_drain;
    logic             w_slot_free;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_pos = c_last_pos - r_cnt;
        end else begin : g_lsb_first
            assign w_pos = r_cnt;
        end
    endgenerate

    // Accumulator with the current beat merged in; used both for mid-frame
    // updates and as the finished word on the completing beat.
    always_comb begin
        w_word        = r_acc;
        w_word[w_pos] = in_bit;
    end

    assign in_ready    = rst_n && !r_pend;
    assign w_accept    = in_valid && in_ready;
    assign w_done      = w_accept && ((r_cnt == c_last_pos) || in_last);
    assign w_len       = {1'b0, r_cnt} + {{SEL_W{1'b0}}, 1'b1};
    assign w_drain     = r_out_valid && out_ready;
    assign w_slot_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_len  <= '0;
            r_out_data  <= '0;
            r_out_len   <= '0;
            r_out_valid <= 1'b0;
        end else if (r_pend) begin
            // Input is stalled; the held word moves out once the slot drains.
            if (w_drain) begin
                r_out_data  <= r_acc;
                r_out_len   <= r_pend_len;
                r_out_valid <= 1'b1;
                r_pend      <= 1'b0;
                r_acc       <= '0;
            end
        end else if (w_done) begin
            r_cnt <= '0;
            if (w_slot_free) begin
                r_out_data  <= w_word;
                r_out_len   <= w_len;
                r_out_valid <= 1'b1;
                r_acc       <= '0;
            end else begin
                r_acc      <= w_word;
                r_pend     <= 1'b1;
                r_pend_len <= w_len;
            end
        end else begin
            if (w_accept) begin
                r_acc <= w_word;
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_len   = r_out_len;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_deser_demux8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deser_demux8
//  Purpose  : Scoreboard bench for deser_demux8 (LSB-first and MSB-first
//             instances driven by the same stimulus).
//  Revision : 1.0
// ============================================================================
module tb_deser_demux8;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] d_lsb;
        logic [7:0] d_msb;
        logic [3:0] len;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic       in_ready0, in_ready1;
    logic [7:0] out_data0, out_data1;
    logic [3:0] out_len0, out_len1;
    logic       out_valid0, out_valid1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_words  = 0;
    bit   stalled  = 0;
    exp_t sbq[$];
    bit   fbits[$];

    deser_demux8 #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready0), .out_data(out_data0),
        .out_len(out_len0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    deser_demux8 #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready1), .out_data(out_data1),
        .out_len(out_len1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: frames are collected as bit lists and
    // turned into words arithmetically; the expected word at the head of the
    // queue must be presented whenever out_valid is high.
    always @(negedge clk) begin
        if (!rst_n) begin
            fbits.delete();
            sbq.delete();
        end else begin
            check("valid_pair", out_valid1, out_valid0);
            check("ready_pair", in_ready1, in_ready0);
            if (out_valid0) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_word: got %02h, expected no word at %0t", out_data0, $time);
                end else begin
                    check("data_lsb", out_data0, sbq[0].d_lsb);
                    check("len_lsb",  out_len0,  sbq[0].len);
                    check("data_msb", out_data1, sbq[0].d_msb);
                    check("len_msb",  out_len1,  sbq[0].len);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        n_words++;
                    end
                end
            end
            if (in_valid && in_ready0) begin
                fbits.push_back(in_bit);
                if (fbits.size() == WIDTH || in_last) begin
                    exp_t e;
                    int   a, b;
                    a = 0;
                    b = 0;
                    foreach (fbits[k]) begin
                        a = a + (int'(fbits[k]) << k);
                        b = b + (int'(fbits[k]) << (WIDTH - 1 - k));
                    end
                    e.d_lsb = a[7:0];
                    e.d_msb = b[7:0];
                    e.len   = 4'(fbits.size());
                    sbq.push_back(e);
                    fbits.delete();
                end
            end
        end
    end

    // One beat; leaves in_valid high so consecutive calls stream back to back.
    task automatic beat(input logic b, input logic l);
        int w;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        w = 0;
        @(negedge clk);
        while (!in_ready0 && w < 100) begin
            stalled = 1;
            w++;
            @(negedge clk);
        end
        if (!in_ready0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] val, input int len, input logic last_flag);
        for (int k = 0; k < len; k++) begin
            beat(val[k], last_flag && (k == len - 1));
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int words_before;
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",  in_ready0,  1'b0);
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_out_data",  out_data0,  8'h00);
        check("rst_out_len",   out_len0,   4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready0, 1'b1);
        @(posedge clk);
        #1;

        // Full frame 1,0,1,1,0,0,1,0 -> 8'h4D, visible one cycle after last beat
        send_frame(8'h4D, 8, 1'b0);
        idle(0);
        @(negedge clk);
        check("full_latency_valid", out_valid0, 1'b1);
        check("full_data", out_data0, 8'h4D);
        @(posedge clk);
        #1;
        idle(2);

        // Short frame 1,1,0 with in_last
        send_frame(8'h03, 3, 1'b1);
        idle(0);
        @(negedge clk);
        check("short_lsb", out_data0, 8'h03);
        check("short_msb", out_data1, 8'hC0);
        check("short_len", out_len0, 4'd3);
        @(posedge clk);
        #1;
        idle(2);

        // Backpressure: two frames with out_ready low
        out_ready = 1'b0;
        send_frame(8'hA5, 8, 1'b0);
        send_frame(8'h3C, 8, 1'b0);
        idle(0);
        @(negedge clk);
        check("bp_ready_low", in_ready0, 1'b0);
        check("bp_hold_a5", out_data0, 8'hA5);
        @(posedge clk);
        #1;
        idle(2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_still_low", in_ready0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_next_3c", out_data0, 8'h3C);
        check("bp_ready_back", in_ready0, 1'b1);
        @(posedge clk);
        #1;
        idle(2);

        // Back-to-back streaming of 4 frames
        stalled      = 0;
        words_before = n_words;
        for (int f = 0; f < 4; f++) begin
            send_frame(8'($urandom), 8, 1'b0);
        end
        idle(3);
        check("stream_no_stall", 32'(stalled), 32'd0);
        check("stream_words", n_words - words_before, 4);

        // Reset mid-frame
        for (int k = 0; k < 5; k++) beat(1'($urandom), 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid_after", out_valid0, 1'b0);
        check("midrst_ready", in_ready0, 1'b1);
        words_before = n_words;
        @(posedge clk);
        #1;
        send_frame(8'hFF, 8, 1'b0);
        idle(0);
        @(negedge clk);
        check("midrst_ff", out_data0, 8'hFF);
        check("midrst_ff_len", out_len0, 4'd8);
        @(posedge clk);
        #1;
        idle(3);
        check("midrst_one_word", n_words - words_before, 1);

        // Reset while a word is pending and another is on the output
        out_ready = 1'b0;
        send_frame(8'($urandom), 8, 1'b0);
        send_frame(8'($urandom), 8, 1'b0);
        idle(0);
        @(negedge clk);
        check("pend_ready_low", in_ready0, 1'b0);
        check("pend_valid_high", out_valid0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("pendrst_valid", out_valid0, 1'b0);
        check("pendrst_ready", in_ready0, 1'b1);
        words_before = n_words;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);
        check("pendrst_no_stale", n_words - words_before, 0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bit    = 1'($urandom);
            in_last   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(0);
        for (int w = 0; w < 50 && (sbq.size() != 0 || out_valid0); w++) begin
            @(posedge clk);
            #1;
        end
        check("final_drain", sbq.size(), 0);
        check("final_idle", out_valid0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
